alu_result_stage: RTL

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// ALU result stage: captures an ALU result byte with its status bits, optionally
// applies a two-step BCD adjust (low nibble, then high nibble), and holds the
// result with registered flags until the consumer acknowledges it.
// Optional feature macro: ALU_RESULT_DECIMAL_EN builds the decimal adjust path.
// Without it, DAA/DSA are ignored and every capture goes straight to HOLD.
module alu_result_stage (
    input  logic       sig_CLK,
    input  logic       sig_RST,
    input  logic       sig_LOAD,
    input  logic [7:0] ALU_IN,
    input  logic       sig_ACR_IN,
    input  logic       sig_AVR_IN,
    input  logic       sig_HC_IN,
    input  logic       sig_DAA,
    input  logic       sig_DSA,
    input  logic       sig_ACK,
    output logic [7:0] ADD_OUT,
    output logic       sig_C,
    output logic       sig_V,
    output logic       sig_Z,
    output logic       sig_N,
    output logic       sig_VALID,
    output logic       sig_BUSY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADJ_LO = 2'd1,
        ADJ_HI = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t state_r;
    logic   load_accept_s;

    // A new operand is taken from IDLE, or from HOLD when the old one is acknowledged.
    assign load_accept_s = sig_LOAD &&
                           ((state_r == IDLE) || ((state_r == HOLD) && sig_ACK));

`ifdef ALU_RESULT_DECIMAL_EN
    logic       daa_r;
    logic       dsa_r;
    logic       hc_r;
    logic       acr_r;
    logic [8:0] lo_sum_s;
    logic [7:0] lo_val_s;
    logic       lo_c_s;
    logic [7:0] hi_val_s;
    logic       hi_c_s;

    // Low-nibble adjust: the working value is ADD_OUT, the running carry is sig_C.
    always_comb begin
        lo_sum_s = {1'b0, ADD_OUT} + 9'h006;
        if (daa_r && (hc_r || (ADD_OUT[3:0] > 4'd9))) begin
            lo_val_s = lo_sum_s[7:0];
            lo_c_s   = sig_C | lo_sum_s[8];
        end else if (dsa_r && !hc_r) begin
            lo_val_s = ADD_OUT - 8'h06;
            lo_c_s   = sig_C;
        end else begin
            lo_val_s = ADD_OUT;
            lo_c_s   = sig_C;
        end
    end

    // High-nibble adjust: DAA may force carry, DSA keys off the captured carry.
    always_comb begin
        if (daa_r && (sig_C || (ADD_OUT[7:4] > 4'd9))) begin
            hi_val_s = ADD_OUT + 8'h60;
            hi_c_s   = 1'b1;
        end else if (dsa_r && !acr_r) begin
            hi_val_s = ADD_OUT - 8'h60;
            hi_c_s   = sig_C;
        end else begin
            hi_val_s = ADD_OUT;
            hi_c_s   = sig_C;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{sig_DAA, sig_DSA, sig_HC_IN};
`endif

    // Result FSM: capture, optional two-step adjust, hold until acknowledged.
    always_ff @(posedge sig_CLK) begin
        if (sig_RST) begin
            state_r   <= IDLE;
            ADD_OUT   <= 8'h00;
            sig_C     <= 1'b0;
            sig_V     <= 1'b0;
            sig_Z     <= 1'b0;
            sig_N     <= 1'b0;
            sig_VALID <= 1'b0;
            sig_BUSY  <= 1'b0;
`ifdef ALU_RESULT_DECIMAL_EN
            daa_r     <= 1'b0;
            dsa_r     <= 1'b0;
            hc_r      <= 1'b0;
            acr_r     <= 1'b0;
`endif
        end else if (load_accept_s) begin
            ADD_OUT  <= ALU_IN;
            sig_C    <= sig_ACR_IN;
            sig_V    <= sig_AVR_IN;
            sig_Z    <= (ALU_IN == 8'h00);
            sig_N    <= ALU_IN[7];
            sig_BUSY <= 1'b1;
`ifdef ALU_RESULT_DECIMAL_EN
            daa_r    <= sig_DAA;
            dsa_r    <= sig_DSA & ~sig_DAA;
            hc_r     <= sig_HC_IN;
            acr_r    <= sig_ACR_IN;
            if (sig_DAA || sig_DSA) begin
                state_r   <= ADJ_LO;
                sig_VALID <= 1'b0;
            end else begin
                state_r   <= HOLD;
                sig_VALID <= 1'b1;
            end
`else
            state_r   <= HOLD;
            sig_VALID <= 1'b1;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    sig_VALID <= 1'b0;
                    sig_BUSY  <= 1'b0;
                end
`ifdef ALU_RESULT_DECIMAL_EN
                ADJ_LO: begin
                    ADD_OUT   <= lo_val_s;
                    sig_C     <= lo_c_s;
                    sig_Z     <= (lo_val_s == 8'h00);
                    sig_N     <= lo_val_s[7];
                    state_r   <= ADJ_HI;
                end
                ADJ_HI: begin
                    ADD_OUT   <= hi_val_s;
                    sig_C     <= hi_c_s;
                    sig_Z     <= (hi_val_s == 8'h00);
                    sig_N     <= hi_val_s[7];
                    sig_VALID <= 1'b1;
                    state_r   <= HOLD;
                end
`endif
                HOLD: begin
                    if (sig_ACK) begin
                        state_r   <= IDLE;
                        sig_VALID <= 1'b0;
                        sig_BUSY  <= 1'b0;
                    end else begin
                        sig_VALID <= 1'b1;
                        sig_BUSY  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    sig_VALID <= 1'b0;
                    sig_BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
